pe_row_ctrl: RTL and testbench
==============================

PE_ROW_CTRL -- requirements
Module: pe_row_ctrl

Interface
REQ-001 SHALL have parameter K, default 3, meaning the number of PEs (filter taps) in the controlled row; legal range 2..8.
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 start  in  1  begin a row job; sampled only in IDLE.
REQ-005 reuse_w  in  1  at start, skip weight load and keep the weights already held in the PEs.
REQ-006 cfg_len  in  8  image pixels in this row; sampled at accepted start.
REQ-007 w_valid/w_ready  in/out  1/1  weight stream handshake; w_data  in  16  weight, Q7.8 signed.
REQ-008 img_valid/img_ready  in/out  1/1  image stream handshake; img_data  in  16  pixel, Q7.8 signed.
REQ-009 pe_weight_val  out  16  weight broadcast to all PEs; pe_weight_en  out  K  one-hot per-PE weight load strobe.
REQ-010 pe_image_val  out  16*K  per-PE pixel, slice i for PE i; pe_image_en  out  K  per-PE image enable.
REQ-011 psum_res  in  16  combinational chained-psum result returned by the PE row.
REQ-012 out_valid/out_ready  out/in  1/1  result handshake; out_data  out  16  result, Q7.8.
REQ-013 busy  out  1  high whenever state is not IDLE; done  out  1  one-cycle job completion pulse; cfg_err  out  1  one-cycle illegal-config pulse.

Function
REQ-014 SHALL implement the states IDLE, LOAD_W, COMPUTE and DONE.
REQ-015 IDLE on start with cfg_len<K: remain IDLE and pulse cfg_err for one cycle.
REQ-016 IDLE on start with cfg_len>=K: go to COMPUTE if reuse_w=1, otherwise to LOAD_W; clear all counters and window valid count.
REQ-017 LOAD_W: w_ready=1; beat j (0..K-1) accepted -> pe_weight_en=one-hot bit j and pe_weight_val=w_data in the same cycle (combinational pass-through).
REQ-018 LOAD_W: after the K-th accepted beat, go to COMPUTE.
REQ-019 pe_weight_en SHALL be all-zero in every other cycle, including LOAD_W cycles with w_valid=0.
REQ-020 Window: K registers win[0..K-1]; on pixel accept, win[j]<=win[j+1] for j<K-1 and win[K-1]<=img_data; pe_image_val slice i=win[i].
REQ-021 img_ready=1 only in COMPUTE with pix_cnt<cfg_len and (out_valid=0 or out_ready=1).
REQ-022 pe_image_en SHALL be all-ones when the window holds >=K pixels of the current job, otherwise all-zero.
REQ-023 out_valid SHALL be registered: set on the edge of an accept that makes pix_cnt>=K.
REQ-024 out_valid SHALL clear on an out_valid&&out_ready edge with no simultaneous accept; a simultaneous accept keeps it set.
REQ-025 out_data=psum_res combinationally while out_valid; result n = sum over i of w[i]*x[n+i]; arithmetic is performed by the PE row, none in this block.
REQ-026 The window and out_data SHALL be held stable while out_valid&&!out_ready.
REQ-027 out_cnt SHALL increment per result handshake; when out_cnt reaches cfg_len-K+1, go to DONE.
REQ-028 DONE: done=1 for one cycle, then go to IDLE; held weights persist for reuse_w.
REQ-029 Latency: first out_valid one cycle after the K-th pixel accept; steady state one result per cycle when out_ready=1.
REQ-030 Handshake inputs outside their owning state SHALL be ignored (w_ready, img_ready = 0).

Reset
REQ-031 On rst: state=IDLE; win, all counters, out_valid, done, cfg_err, busy=0; pe_weight_en, pe_image_en=0; w_ready, img_ready=0.
REQ-032 rst asserted mid-job SHALL abort the job with no done pulse; the next job SHALL require reuse_w=0 to yield defined weights.

Verification
REQ-033 Scenario 1: K=3, reuse_w=0, weights 0x0100,0x0200,0x0100, cfg_len=4, pixels 0x0100..0x0400, behavioral PE row -> out_data 0x0800 then 0x0C00, then done pulse.
REQ-034 Scenario 2: out_ready held low 5 cycles after the first out_valid -> img_ready=0, out_data and pe_image_val stable, no pixel lost.
REQ-035 Scenario 3: start with cfg_len=2 (K=3) -> cfg_err pulse, busy stays 0, no handshakes.
REQ-036 Scenario 4: second job with reuse_w=1 -> no w_ready cycle; results use the prior weights.
REQ-037 Scenario 5: rst asserted after 2 pixels -> all outputs at reset values next cycle; a following normal job produces correct results.
REQ-038 Scenario 6: cfg_len=255 with continuous valid/ready -> 253 results, one per cycle, done after the last.

Source files
------------

// File: rtl/pe_row_ctrl_if.sv
`timescale 1ns/1ps
// pe_row_ctrl_if
// Bundles every non-clock/reset signal of pe_row_ctrl.
//   job control : start, reuse_w, cfg_len -> busy, done, cfg_err
//   weight in   : w_valid/w_ready, w_data (Q7.8)
//   image in    : img_valid/img_ready, img_data (Q7.8)
//   PE row side : pe_weight_val/pe_weight_en, pe_image_val/pe_image_en, psum_res
//   result out  : out_valid/out_ready, out_data (Q7.8)
// Modport slave is the controller's view; master is the view of whatever
// drives jobs and streams and hosts the PE row.
interface pe_row_ctrl_if #(
  parameter int K = 3
);
  logic              start;
  logic              reuse_w;
  logic [7:0]        cfg_len;
  logic              w_valid;
  logic              w_ready;
  logic [15:0]       w_data;
  logic              img_valid;
  logic              img_ready;
  logic [15:0]       img_data;
  logic [15:0]       pe_weight_val;
  logic [K-1:0]      pe_weight_en;
  logic [16*K-1:0]   pe_image_val;
  logic [K-1:0]      pe_image_en;
  logic [15:0]       psum_res;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic              busy;
  logic              done;
  logic              cfg_err;

  modport slave (
    input  start, reuse_w, cfg_len,
    input  w_valid, w_data,
    input  img_valid, img_data,
    input  psum_res, out_ready,
    output w_ready, img_ready,
    output pe_weight_val, pe_weight_en, pe_image_val, pe_image_en,
    output out_valid, out_data, busy, done, cfg_err
  );

  modport master (
    output start, reuse_w, cfg_len,
    output w_valid, w_data,
    output img_valid, img_data,
    output psum_res, out_ready,
    input  w_ready, img_ready,
    input  pe_weight_val, pe_weight_en, pe_image_val, pe_image_en,
    input  out_valid, out_data, busy, done, cfg_err
  );
endinterface

// File: rtl/pe_row_ctrl.sv
`timescale 1ns/1ps
// pe_row_ctrl
// Sequences one row of a K-tap 1-D convolution on an external PE row.
// A job optionally loads K weights (one per PE), then streams cfg_len pixels
// through a K-deep sliding window that feeds every PE in parallel. Once the
// window is full, each window position yields one chained-psum result that
// the PE row computes combinationally; this block only steers data and
// applies backpressure, it does no arithmetic.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  pe_row_ctrl_if.slave (job control, weight/image/result streams,
//        PE row broadcast and enables)
module pe_row_ctrl #(
  parameter int K = 3
) (
  input  logic         clk,
  input  logic         rst,
  pe_row_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DONE} state_t;

  localparam int             WCW    = $clog2(K);
  localparam logic [7:0]     K_LEN  = 8'(K);
  localparam logic [WCW-1:0] W_LAST = WCW'(K - 1);
  localparam logic [K-1:0]   PE0    = K'(1);

  state_t         state, state_nxt;
  logic [WCW-1:0] w_cnt;
  logic [7:0]     pix_cnt;
  logic [7:0]     out_cnt;
  logic [7:0]     len_q;
  logic [15:0]    win [K];
  logic           out_valid_q;
  logic           cfg_err_q;

  logic start_ok, start_bad;
  logic w_acc, img_rdy, img_acc, out_hs, last_res, win_full;

  assign start_ok  = (state == IDLE) && bus.start && (bus.cfg_len >= K_LEN);
  assign start_bad = (state == IDLE) && bus.start && (bus.cfg_len <  K_LEN);
  assign w_acc     = (state == LOAD_W) && bus.w_valid;
  assign out_hs    = out_valid_q && bus.out_ready;
  // A new pixel may only enter when the current result is leaving (or there
  // is none), so the window never shifts under a stalled result.
  assign img_rdy   = (state == COMPUTE) && (pix_cnt < len_q) &&
                     (!out_valid_q || bus.out_ready);
  assign img_acc   = img_rdy && bus.img_valid;
  // cfg_len-K+1 results per job; out_cnt counts completed ones.
  assign last_res  = out_hs && (out_cnt == len_q - K_LEN);
  assign win_full  = (pix_cnt >= K_LEN);

  // State register and job counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      w_cnt       <= '0;
      pix_cnt     <= '0;
      out_cnt     <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of its neighbours, independent of statement order.
      state     <= state_nxt;
      cfg_err_q <= start_bad;
      if (start_ok) begin
        w_cnt       <= '0;
        pix_cnt     <= '0;
        out_cnt     <= '0;
        len_q       <= bus.cfg_len;
        out_valid_q <= 1'b0;
      end else begin
        if (w_acc)   w_cnt   <= w_cnt + 1'b1;
        if (img_acc) pix_cnt <= pix_cnt + 8'd1;
        if (out_hs)  out_cnt <= out_cnt + 8'd1;
        // An accept that fills (or keeps full) the window always produces the
        // next result, even when the previous one leaves on the same edge.
        if (img_acc && (pix_cnt + 8'd1 >= K_LEN)) out_valid_q <= 1'b1;
        else if (out_hs)                          out_valid_q <= 1'b0;
      end
    end
  end

  // Sliding pixel window: oldest pixel in win[0], newest in win[K-1].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the window is a handful of flops, not a RAM, so it takes the
      // async reset and the PE inputs are zero rather than stale after rst.
      for (int j = 0; j < K; j++) win[j] <= '0;
    end else if (img_acc) begin
      for (int j = 0; j < K - 1; j++) win[j] <= win[j + 1];
      win[K - 1] <= bus.img_data;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned before the case so no path leaves state_nxt
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = bus.reuse_w ? COMPUTE : LOAD_W;
      LOAD_W:  if (w_acc && (w_cnt == W_LAST)) state_nxt = COMPUTE;
      COMPUTE: if (last_res) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; handshakes are only honoured in their owning state.
  always_comb begin
    bus.w_ready      = 1'b0;
    bus.img_ready    = 1'b0;
    bus.pe_weight_en = '0;
    bus.pe_image_en  = '0;
    bus.done         = 1'b0;
    case (state)
      LOAD_W: begin
        bus.w_ready = 1'b1;
        if (bus.w_valid) bus.pe_weight_en = PE0 << w_cnt;
      end
      COMPUTE: begin
        bus.img_ready = img_rdy;
        if (win_full) bus.pe_image_en = '1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy          = (state != IDLE);
  assign bus.cfg_err       = cfg_err_q;
  assign bus.pe_weight_val = bus.w_data;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_valid_q ? bus.psum_res : 16'h0000;

  for (genvar i = 0; i < K; i++) begin : g_img
    assign bus.pe_image_val[16*i +: 16] = win[i];
  end

endmodule

// File: tb/tb_pe_row_ctrl.sv
`timescale 1ns/1ps
// tb_pe_row_ctrl
// Drives randomized row jobs into pe_row_ctrl with a behavioural PE row
// attached. Expected results come from the convolution definition applied to
// the weight and pixel lists of each job and are queued at stimulus time; a
// monitor pops and compares on every result handshake.
module tb_pe_row_ctrl;
  localparam int K = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_row_ctrl_if #(.K(K)) bus ();

  pe_row_ctrl #(.K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- behavioural PE row ----------------
  logic [15:0] pe_w [K];
  always @(posedge clk)
    for (int i = 0; i < K; i++)
      if (bus.pe_weight_en[i]) pe_w[i] <= bus.pe_weight_val;

  always_comb begin
    logic signed [63:0] acc;
    acc = '0;
    for (int i = 0; i < K; i++)
      acc = acc + 64'($signed(pe_w[i])) * 64'($signed(bus.pe_image_val[16*i +: 16]));
    bus.psum_res = acc[23:8];
  end

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] model_w [K];
  logic [15:0] pix_q [$];
  logic [15:0] exp_q [$];
  int n_exp, hs_cnt, done_cnt, wr_cnt;
  int first_ov_cyc, first_hs_cyc, last_hs_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Result n of the row: sum_i w[i]*x[n+i] in Q7.8.
  function automatic logic [15:0] ref_result(input int n);
    logic signed [63:0] acc;
    acc = '0;
    for (int i = 0; i < K; i++)
      acc = acc + 64'($signed(model_w[i])) * 64'($signed(pix_q[n + i]));
    return acc[23:8];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    hs_cnt = 0; done_cnt = 0; wr_cnt = 0;
    first_ov_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.w_ready) wr_cnt++;
        if (bus.done) done_cnt++;
        if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (bus.out_valid && bus.out_ready) begin
          if (hs_cnt == 0) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
          hs_cnt++;
          if (exp_q.size() > 0) check("result", bus.out_data, exp_q.pop_front());
          else                  check("result_count", hs_cnt, n_exp);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
    check({tag, "_w_ready"},   bus.w_ready, 0);
    check({tag, "_img_ready"}, bus.img_ready, 0);
    check({tag, "_done"},      bus.done, 0);
    check({tag, "_cfg_err"},   bus.cfg_err, 0);
    check({tag, "_pe_w_en"},   bus.pe_weight_en, 0);
    check({tag, "_pe_i_en"},   bus.pe_image_en, 0);
    check({tag, "_pe_i_val"},  bus.pe_image_val, 0);
  endtask

  // rdy_mode: 0 = out_ready always 1, 1 = random, 2 = stall 5 cycles at first result.
  task automatic run_job(input string tag, input bit fixed, input bit reuse, input int len,
                         input int rdy_mode, input bit gaps, input int abort_at);
    int wi, pi, cycles, stall_left, budget, done0, wr0, acc_cyc;
    bit finished, stalled_once, aborted;
    logic [K-1:0] oh;
    logic [16*K-1:0] win_exp;

    if (!reuse)
      for (int i = 0; i < K; i++)
        model_w[i] = fixed ? ((i == 1) ? 16'h0200 : 16'h0100) : 16'($urandom);
    pix_q.delete();
    exp_q.delete();
    for (int n = 0; n < len; n++)
      pix_q.push_back(fixed ? 16'((n + 1) << 8) : 16'($urandom));
    n_exp = len - K + 1;
    for (int n = 0; n < n_exp; n++) exp_q.push_back(ref_result(n));

    hs_cnt = 0; first_ov_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
    done0 = done_cnt; wr0 = wr_cnt; acc_cyc = -1;
    wi = 0; pi = 0; cycles = 0; stall_left = 0;
    finished = 0; stalled_once = 0; aborted = 0;
    budget = 20 * len + 200;

    @(posedge clk); #1;
    bus.start = 1'b1; bus.reuse_w = reuse; bus.cfg_len = 8'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;

    while (!finished && cycles < budget) begin
      if (reuse) begin
        bus.w_valid = 1'b1;                // must be ignored
        bus.w_data  = 16'($urandom);
      end else begin
        bus.w_valid = (wi < K) && (!gaps || $urandom_range(0, 3) != 0);
        if (wi < K) bus.w_data = model_w[wi];
      end
      bus.img_valid = (pi < len) && (!gaps || $urandom_range(0, 3) != 0);
      if (pi < len) bus.img_data = pix_q[pi];
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (!stalled_once && bus.out_valid) begin
            stalled_once = 1;
            stall_left = 5;
          end
          bus.out_ready = (stall_left == 0);
        end
      endcase

      @(negedge clk);
      if (cycles == 0) check({tag, "_busy"}, bus.busy, 1);
      if (stall_left > 0) begin
        for (int i = 0; i < K; i++) win_exp[16*i +: 16] = pix_q[pi - K + i];
        check({tag, "_stall_img_ready"}, bus.img_ready, 0);
        check({tag, "_stall_out_data"}, bus.out_data, exp_q[0]);
        check({tag, "_stall_window"}, bus.pe_image_val, win_exp);
        stall_left--;
      end
      if (bus.w_ready) begin
        if (bus.w_valid) begin
          oh = '0;
          oh[wi] = 1'b1;
          check({tag, "_w_en"}, bus.pe_weight_en, oh);
          check({tag, "_w_val"}, bus.pe_weight_val, model_w[wi]);
          wi++;
        end else begin
          check({tag, "_w_en_idle"}, bus.pe_weight_en, 0);
        end
      end
      if (bus.img_valid && bus.img_ready) begin
        pi++;
        if (pi == K) acc_cyc = cyc + 1;
      end
      if (bus.done) finished = 1;
      @(posedge clk); #1;
      cycles++;

      if (abort_at > 0 && pi == abort_at && !finished) begin
        rst = 1'b1;
        bus.w_valid = 1'b0; bus.img_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs({tag, "_abort"});
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        aborted = 1;
        finished = 1;
      end
    end

    bus.w_valid = 1'b0; bus.img_valid = 1'b0; bus.out_ready = 1'b0;
    if (aborted) begin
      check({tag, "_abort_no_done"}, done_cnt - done0, 0);
    end else begin
      check({tag, "_finished"}, finished, 1);
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_done_pulses"}, done_cnt - done0, 1);
      check({tag, "_results"}, hs_cnt, n_exp);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      check({tag, "_idle_busy"}, bus.busy, 0);
      if (reuse) check({tag, "_no_w_ready"}, wr_cnt - wr0, 0);
      if (rdy_mode == 0 && !gaps) begin
        check({tag, "_first_latency"}, first_ov_cyc, acc_cyc);
        check({tag, "_one_per_cycle"}, last_hs_cyc - first_hs_cyc, n_exp - 1);
      end
    end
  endtask

  task automatic cfg_err_test(input string tag, input int len);
    int err_cnt, busy_cnt, rdy_cnt;
    err_cnt = 0; busy_cnt = 0; rdy_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.reuse_w = 1'b0; bus.cfg_len = 8'(len);
    bus.w_valid = 1'b1; bus.img_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.cfg_err) err_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.w_ready || bus.img_ready || bus.out_valid) rdy_cnt++;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.w_valid = 1'b0; bus.img_valid = 1'b0; bus.out_ready = 1'b0;
    check({tag, "_pulses"}, err_cnt, 1);
    check({tag, "_busy"}, busy_cnt, 0);
    check({tag, "_handshakes"}, rdy_cnt, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.reuse_w = 1'b0; bus.cfg_len = '0;
    bus.w_valid = 1'b0; bus.w_data = '0;
    bus.img_valid = 1'b0; bus.img_data = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_job("s1_basic",   1'b1, 1'b0, 4,   0, 1'b0, 0);
    run_job("s2_stall",   1'b0, 1'b0, 8,   2, 1'b0, 0);
    cfg_err_test("s3_cfg_err", 2);
    run_job("s4_reuse",   1'b0, 1'b1, 10,  1, 1'b1, 0);
    run_job("len_eq_k",   1'b0, 1'b0, K,   0, 1'b0, 0);
    for (int r = 0; r < 4; r++)
      run_job("rand", 1'b0, 1'b0, $urandom_range(K, 20), 1, 1'b1, 0);
    run_job("s5_abort",   1'b0, 1'b0, 10,  0, 1'b0, 2);
    run_job("s5_after",   1'b0, 1'b0, 6,   1, 1'b1, 0);
    run_job("s6_long",    1'b0, 1'b0, 255, 0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
